// File: rtl/gshare_bht_if.sv
// rtl/gshare_bht_if.sv - lookup/prediction/update bundle between fetch, execute and gshare_bht
interface gshare_bht_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int HIST_BITS  = 6
);
    logic                  ready;
    logic                  lookup_valid;
    logic [ADDR_WIDTH-1:0] lookup_addr;
    logic                  pred_valid;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_index;
    logic [HIST_BITS-1:0]  pred_ghr;
    logic                  upd_valid;
    logic [ADDR_WIDTH-1:0] upd_index;
    logic                  upd_taken;
    logic                  upd_mispredict;
    logic [HIST_BITS-1:0]  upd_ghr;

    modport master (
        input  ready, pred_valid, pred_taken, pred_index, pred_ghr,
        output lookup_valid, lookup_addr,
        output upd_valid, upd_index, upd_taken, upd_mispredict, upd_ghr
    );

    modport slave (
        output ready, pred_valid, pred_taken, pred_index, pred_ghr,
        input  lookup_valid, lookup_addr,
        input  upd_valid, upd_index, upd_taken, upd_mispredict, upd_ghr
    );
endinterface

// File: rtl/gshare_bht.sv
// rtl/gshare_bht.sv - saturating-counter branch predictor with speculative GHR, repair and bypass
// BHT_GSHARE_EN: XOR the GHR into the table index; undefined gives a bimodal (address-only) index.
module gshare_bht #(
    parameter int ADDR_WIDTH   = 6,
    parameter int COUNTER_BITS = 2,
    parameter int HIST_BITS    = 6,
    parameter int INIT_VALUE   = 2**(COUNTER_BITS-1)-1
) (
    input logic         clk,
    input logic         rst_n,
    gshare_bht_if.slave bus
);
    localparam int                      ENTRIES  = 2**ADDR_WIDTH;
    localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;
    localparam logic [COUNTER_BITS-1:0] CNT_ONE  = COUNTER_BITS'(1);
    localparam logic [COUNTER_BITS-1:0] CNT_INIT = COUNTER_BITS'(INIT_VALUE);
    localparam logic [0:0]              ST_INIT  = 1'b0;
    localparam logic [0:0]              ST_RUN   = 1'b1;

    logic [0:0]              state;
    logic [ADDR_WIDTH-1:0]   init_ptr;
    logic [HIST_BITS-1:0]    ghr;
    logic [COUNTER_BITS-1:0] bht [ENTRIES];

    logic [ADDR_WIDTH-1:0]   idx;
    logic [COUNTER_BITS-1:0] upd_cnt;
    logic [COUNTER_BITS-1:0] upd_cnt_next;
    logic [COUNTER_BITS-1:0] look_cnt;
    logic                    run;
    logic                    do_upd;
    logic                    do_repair;
    logic                    do_lookup;
    logic                    look_taken;
    logic [HIST_BITS:0]      spec_shift;
    logic [HIST_BITS:0]      repair_shift;

`ifdef BHT_GSHARE_EN
    assign idx = bus.lookup_addr ^ ADDR_WIDTH'(ghr);
`else
    assign idx = bus.lookup_addr;
`endif

    assign run       = (state == ST_RUN);
    assign do_upd    = run && bus.upd_valid;
    assign do_repair = do_upd && bus.upd_mispredict;
    assign do_lookup = run && bus.lookup_valid && !do_repair;

    assign upd_cnt = bht[bus.upd_index];

    always_comb begin
        upd_cnt_next = upd_cnt;
        if (bus.upd_taken && (upd_cnt != CNT_MAX)) begin
            upd_cnt_next = upd_cnt + CNT_ONE;
        end else if (!bus.upd_taken && (upd_cnt != '0)) begin
            upd_cnt_next = upd_cnt - CNT_ONE;
        end
    end

    // A same-cycle update to the looked-up entry must be seen by the prediction.
    assign look_cnt   = (do_upd && (bus.upd_index == idx)) ? upd_cnt_next : bht[idx];
    assign look_taken = look_cnt[COUNTER_BITS-1];

    // One extra bit on the left drops the oldest history bit and works for HIST_BITS=1.
    assign spec_shift   = {ghr, look_taken};
    assign repair_shift = {bus.upd_ghr, bus.upd_taken};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_INIT;
            init_ptr       <= '0;
            ghr            <= '0;
            bus.ready      <= 1'b0;
            bus.pred_valid <= 1'b0;
            bus.pred_taken <= 1'b0;
            bus.pred_index <= '0;
            bus.pred_ghr   <= '0;
        end else begin
            bus.pred_valid <= do_lookup;
            if (state == ST_INIT) begin
                init_ptr <= init_ptr + ADDR_WIDTH'(1);
                if (init_ptr == '1) begin
                    state     <= ST_RUN;
                    bus.ready <= 1'b1;
                end
            end
            if (do_repair) begin
                ghr <= repair_shift[HIST_BITS-1:0];
            end else if (do_lookup) begin
                ghr            <= spec_shift[HIST_BITS-1:0];
                bus.pred_taken <= look_taken;
                bus.pred_index <= idx;
                bus.pred_ghr   <= ghr;
            end
        end
    end

    // The table has no reset: the init sweep rewrites every entry after each reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (!run) begin
                bht[init_ptr] <= CNT_INIT;
            end else if (bus.upd_valid) begin
                bht[bus.upd_index] <= upd_cnt_next;
            end
        end
    end
endmodule
